mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares the single memory port of the DUT memory model between two requesters: the core data port (requester 0) and the testbench program loader/debug port (requester 1). It serializes accesses with round-robin priority, drives the memory with registered address, data and strobes, and routes read data back to the owner. It sits in `dut_top` between the requesters and the memory model.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; must be 32 (4 byte lanes).
- `MEM_LATENCY`, 1: cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.

Ports (per-requester signals are arrays indexed [1:0]; index 0 = core, 1 = loader/debug):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in [1:0]: access request, held until `gnt`.
- `we` in [1:0]: 1 = write, 0 = read.
- `addr` in [1:0][ADDR_WIDTH]: byte address; bits [1:0] ignored.
- `wdata` in [1:0][DATA_WIDTH]: write data.
- `be` in [1:0][4]: byte enables (writes only).
- `gnt` out [1:0]: one-cycle accept pulse.
- `rvalid` out [1:0]: one-cycle read-data-valid pulse.
- `rdata` out DATA_WIDTH: read data, shared and qualified by `rvalid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 4: byte write strobes; 0 for reads.
- `mem_addr` out ADDR_WIDTH: word-aligned address (bits [1:0] = 0).
- `mem_wdata` out DATA_WIDTH: write data.
- `mem_rdata` in DATA_WIDTH: memory read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any `req` is high, select an owner and capture the owner's `we`, `addr`, `wdata` and `be` into registers, then go to ACCESS. Otherwise stay in IDLE.
- Owner selection: if only one requester is high, it wins. If both are high, the winner is the requester that is not `last_owner`. `last_owner` updates on every grant.
- ACCESS (exactly 1 cycle):
  - `mem_en`=1. `mem_addr`, `mem_wdata` and `mem_we` (= captured `be` for writes, 0 for reads) driven from the captured registers.
  - `gnt[owner]`=1.
  - Next state: a write goes to IDLE. A read goes to WAIT if `MEM_LATENCY`>1, else to RESP.
- WAIT: a 4-bit counter counts `MEM_LATENCY`-1 cycles, then the FSM goes to RESP.
- RESP (exactly 1 cycle): `rdata` = `mem_rdata` sampled this cycle, `rvalid[owner]`=1, then go to IDLE.
- Requester rule: `req`, `we`, `addr`, `wdata` and `be` stay stable from assertion until `gnt`. After `gnt`, a requester may deassert or present a new request; the new request is considered in the next IDLE.
- Only one transaction is outstanding at a time. Requests arriving in ACCESS, WAIT or RESP wait for IDLE.
- `be`=0 on a write: the access is still performed with `mem_we`=0 and still gets `gnt`; there is no special case.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, FSM=IDLE, `last_owner`=1 (the core wins the first contention).
- Write: `req` first seen high in cycle N → `gnt` and `mem_en` in cycle N+1 → FSM back in IDLE in cycle N+2. Throughput is 1 write per 2 cycles.
- Read: `gnt` and `mem_en` in N+1 → `rvalid` in N+1+`MEM_LATENCY` → IDLE in N+2+`MEM_LATENCY`.
- All outputs are registered; there is no combinational path from `req` to `gnt`.
- Simultaneous requests in IDLE: round-robin as above. Under constant contention the grants alternate 0,1,0,1…
- Counter: loads `MEM_LATENCY`-2 on entering WAIT and decrements to 0. There is no wrap.
- Reset asserted mid-transaction: asynchronous return to IDLE with all outputs at reset values. An in-flight read is dropped (no `rvalid`), and the requester must re-request.

## Structure
- Shared package `hfrv_bus_pkg` holds:
  - requester index constants `REQ_CORE`=0 and `REQ_DBG`=1;
  - the FSM state enum `arb_state_t`;
  - a packed struct `bus_req_t` with fields `we`, `addr`, `wdata` and `be`.
- One natural sub-module: `rr_pick2`, a 2-way round-robin selector. Inputs are `req[1:0]` and `last_owner`; outputs are `valid` and `owner`. It is purely combinational and is instantiated once.

## Test plan
- Single core write, addr 0x104, wdata 0xDEADBEEF, be 4'b1111 → one-cycle `gnt[0]` with `mem_en`=1, `mem_addr`=0x104 and `mem_we`=4'hF in the next cycle; back in IDLE one cycle later.
- Read with `MEM_LATENCY`=3 from requester 1, addr 0x200, memory returns 0x12345678 → `gnt[1]` in cycle N+1 and `rvalid[1]` with `rdata`=0x12345678 in cycle N+4; `rvalid[0]` stays 0.
- Both requesters hold `req` for 6 grants → grant order 0,1,0,1,0,1 with no back-to-back grants.
- Unaligned addr 0x107 with be 4'b0100 → `mem_addr`=0x104, `mem_we`=4'b0100.
- `rst_n` pulsed low during WAIT → all outputs are 0 immediately, no `rvalid` appears, and the next request after reset is serviced normally.
- `req` is stable but `wdata` changes after `gnt` → memory sees the originally captured wdata.

Source files
------------

// File: rtl/hfrv_bus_pkg.sv
// ============================================================================
// Module      : hfrv_bus_pkg
// Description : Shared bus types for the memory-port arbiter: requester ids,
//               arbiter FSM states and the captured request record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hfrv_bus_pkg;

    localparam int REQ_CORE   = 0;
    localparam int REQ_DBG    = 1;
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_BE_W-1:0]   be;
    } bus_req_t;

    // The memory is word-organised; byte offset bits never reach it.
    function automatic logic [BUS_ADDR_W-1:0] word_align(input logic [BUS_ADDR_W-1:0] a);
        return {a[BUS_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Two-requester request/grant/read-data bundle feeding the
//               memory-port arbiter. Index 0 = core, index 1 = loader/debug.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 req;
    logic [1:0]                 we;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0][3:0]            be;
    logic [1:0]                 gnt;
    logic [1:0]                 rvalid;
    logic [DATA_WIDTH-1:0]      rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin selector; on contention the
//               requester that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic       last_owner,
    output logic            valid,
    output logic            owner
);
    always_comb begin
        valid = |req;
        owner = (&req) ? ~last_owner : req[1];
    end
endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the core and the loader/debug
//               port; one transaction at a time, round-robin on contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import hfrv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUS_ADDR_W,
    parameter int DATA_WIDTH  = BUS_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    mem_port_arbiter_if.slave           bus,
    output logic                        mem_en,
    output logic [3:0]                  mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  wire logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int         c_wait_load_i = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
    localparam logic [3:0] c_wait_load   = 4'(c_wait_load_i);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic       r_is_read;
    logic [3:0] r_cnt;
    logic [1:0] r_gnt;
    logic [1:0] r_rvalid;

    logic       w_valid;
    logic       w_owner;
    bus_req_t   w_sel;

    rr_pick2 u_pick (
        .req        (bus.req),
        .last_owner (r_last_owner),
        .valid      (w_valid),
        .owner      (w_owner)
    );

    always_comb begin
        w_sel.we    = bus.we[w_owner];
        w_sel.addr  = BUS_ADDR_W'(bus.addr[w_owner]);
        w_sel.wdata = BUS_DATA_W'(bus.wdata[w_owner]);
        w_sel.be    = bus.be[w_owner];
    end

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rvalid;
    // Read data is the memory output passed through while in RESP, zero otherwise.
    assign bus.rdata  = (r_state == RESP) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_is_read    <= 1'b0;
            r_cnt        <= 4'd0;
            r_gnt        <= 2'b00;
            r_rvalid     <= 2'b00;
            mem_en       <= 1'b0;
            mem_we       <= 4'b0000;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            mem_en   <= 1'b0;
            mem_we   <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        // Capture straight into the memory-facing registers so
                        // ACCESS drives them with no further logic.
                        r_owner         <= w_owner;
                        r_last_owner    <= w_owner;
                        r_is_read       <= ~w_sel.we;
                        r_gnt[REQ_CORE] <= ~w_owner;
                        r_gnt[REQ_DBG]  <= w_owner;
                        mem_en          <= 1'b1;
                        mem_we          <= w_sel.we ? w_sel.be : 4'b0000;
                        mem_addr        <= ADDR_WIDTH'(word_align(w_sel.addr));
                        mem_wdata       <= DATA_WIDTH'(w_sel.wdata);
                        r_state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_is_read) begin
                        r_state <= IDLE;
                    end else if (MEM_LATENCY > 1) begin
                        r_cnt   <= c_wait_load;
                        r_state <= WAIT;
                    end else begin
                        r_rvalid <= r_owner ? 2'b10 : 2'b01;
                        r_state  <= RESP;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rvalid <= r_owner ? 2'b10 : 2'b01;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a 3-cycle memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        r0_req, r1_req, r0_we, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [3:0]  r0_be, r1_be;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    assign bus_if.req   = {r1_req, r0_req};
    assign bus_if.we    = {r1_we, r0_we};
    assign bus_if.addr  = {r1_addr, r0_addr};
    assign bus_if.wdata = {r1_wdata, r0_wdata};
    assign bus_if.be    = {r1_be, r0_be};

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data valid LAT cycles after the mem_en cycle.
    logic [31:0] mem [256];
    logic [31:0] pipe [LAT];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h80] = 32'h12345678;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            pipe[0] <= mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
            pipe[0] <= 32'hBAD0BAD0;
        end
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct {
        bit          rd;
        int          who;
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_g(input int who, input int c, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] d);
        exp_t e;
        e.rd = 1'b0; e.who = who; e.cyc = c; e.addr = a; e.we = w; e.data = d;
        q.push_back(e);
    endtask

    task automatic push_r(input int who, input int c, input logic [31:0] d);
        exp_t e;
        e.rd = 1'b1; e.who = who; e.cyc = c; e.addr = 32'h0; e.we = 4'h0; e.data = d;
        q.push_back(e);
    endtask

    // Monitor: every grant or read response must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] ev;
        if (mem_en && (bus_if.gnt == 2'b00)) begin
            total++; bad++;
            $display("FAIL mem_en_without_gnt: actual=1 required=0");
        end
        if ((bus_if.gnt != 2'b00) || (bus_if.rvalid != 2'b00)) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: actual gnt=%b rvalid=%b required=none",
                         bus_if.gnt, bus_if.rvalid);
            end else begin
                e  = q.pop_front();
                ev = (e.who == 0) ? 2'b01 : 2'b10;
                if (!e.rd) begin
                    check("gnt_vec",   64'(bus_if.gnt), 64'(ev));
                    check("gnt_cycle", 64'(cyc), 64'(e.cyc));
                    check("mem_en",    64'(mem_en), 64'd1);
                    check("mem_addr",  64'(mem_addr), 64'(e.addr));
                    check("mem_we",    64'(mem_we), 64'(e.we));
                    check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                    check("rvalid_in_access", 64'(bus_if.rvalid), 64'd0);
                end else begin
                    check("rvalid_vec",   64'(bus_if.rvalid), 64'(ev));
                    check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                    check("rdata",        64'(bus_if.rdata), 64'(e.data));
                    check("gnt_in_resp",  64'(bus_if.gnt), 64'd0);
                end
            end
        end
    end

    task automatic do_req(input int idx, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input logic [31:0] d_after);
        bit got = 1'b0;
        int k = 0;
        if (idx == 0) begin
            r0_we = w; r0_addr = a; r0_wdata = d; r0_be = b; r0_req = 1'b1;
        end else begin
            r1_we = w; r1_addr = a; r1_wdata = d; r1_be = b; r1_req = 1'b1;
        end
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus_if.gnt[idx]) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL gnt_wait req%0d: actual=no_gnt required=gnt", idx);
        end
        if (idx == 0) begin
            r0_req = 1'b0; r0_wdata = d_after;
        end else begin
            r1_req = 1'b0; r1_wdata = d_after;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},       64'(bus_if.gnt), 64'd0);
        check({tag, "_rvalid"},    64'(bus_if.rvalid), 64'd0);
        check({tag, "_rdata"},     64'(bus_if.rdata), 64'd0);
        check({tag, "_mem_en"},    64'(mem_en), 64'd0);
        check({tag, "_mem_we"},    64'(mem_we), 64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        int n;
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0; r0_be = 0; r1_be = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        #1 rst_n = 1'b1;

        // Single core write
        @(posedge clk); #1; n = cyc;
        push_g(0, n + 1, 32'h104, 4'hF, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
        drain();

        // Debug-port read, 3-cycle memory
        @(posedge clk); #1; n = cyc;
        push_g(1, n + 1, 32'h200, 4'h0, 32'h0);
        push_r(1, n + 4, 32'h12345678);
        do_req(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0);
        drain();

        // Constant contention: grants alternate, core first
        @(posedge clk); #1; n = cyc;
        for (int k = 0; k < 3; k++) begin
            push_g(0, n + 1 + 4*k, 32'h300 + 32'(4*k), 4'hF, 32'hC0DE0000 + 32'(k));
            push_g(1, n + 3 + 4*k, 32'h380 + 32'(4*k), 4'hF, 32'hDB600000 + 32'(k));
        end
        fork
            begin
                for (int k = 0; k < 3; k++)
                    do_req(0, 1'b1, 32'h300 + 32'(4*k), 32'hC0DE0000 + 32'(k), 4'hF,
                           32'hC0DE0000 + 32'(k));
            end
            begin
                for (int k = 0; k < 3; k++)
                    do_req(1, 1'b1, 32'h380 + 32'(4*k), 32'hDB600000 + 32'(k), 4'hF,
                           32'hDB600000 + 32'(k));
            end
        join
        drain();

        // Unaligned single-byte write
        @(posedge clk); #1; n = cyc;
        push_g(0, n + 1, 32'h104, 4'b0100, 32'h00AB0000);
        do_req(0, 1'b1, 32'h107, 32'h00AB0000, 4'b0100, 32'h00AB0000);
        drain();

        // Write with no byte enables still gets an access
        @(posedge clk); #1; n = cyc;
        push_g(1, n + 1, 32'h10C, 4'h0, 32'hFFFFFFFF);
        do_req(1, 1'b1, 32'h10C, 32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF);
        drain();

        // wdata changes after gnt; memory must keep the captured value
        @(posedge clk); #1; n = cyc;
        push_g(0, n + 1, 32'h108, 4'hF, 32'h11112222);
        do_req(0, 1'b1, 32'h108, 32'h11112222, 4'hF, 32'h99999999);
        drain();
        @(posedge clk); #1; n = cyc;
        push_g(1, n + 1, 32'h108, 4'h0, 32'h0);
        push_r(1, n + 4, 32'h11112222);
        do_req(1, 1'b0, 32'h108, 32'h0, 4'h0, 32'h0);
        drain();

        // Reset during WAIT drops the read
        @(posedge clk); #1; n = cyc;
        push_g(1, n + 1, 32'h200, 4'h0, 32'h0);
        do_req(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("queue_after_reset", 64'(q.size()), 64'd0);

        // Normal service after reset; reads back the merged word at 0x104
        @(posedge clk); #1; n = cyc;
        push_g(0, n + 1, 32'h104, 4'h0, 32'h0);
        push_r(0, n + 4, 32'hDEABBEEF);
        do_req(0, 1'b0, 32'h104, 32'h0, 4'h0, 32'h0);
        drain();

        repeat (3) @(posedge clk);
        check("queue_final", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
